// File: rtl/fifo_pkg.sv
// Shared constants for the 144-bit x 256-word first-word-fall-through FIFO.
package fifo_pkg;

  localparam int FIFO_WIDTH  = 144;
  localparam int FIFO_DEPTH  = 256;
  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W  = FIFO_ADDR_W + 1;

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port memory: one synchronous write port, one synchronous read
// port with read enable. Contents are never reset so it maps onto block RAM.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: registered output, only updated when a new head is fetched.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fwft_fifo_w144_d256.sv
// Single-clock first-word-fall-through FIFO, 144 bits x 256 words.
// The RAM read register holds the head word; a word becomes visible on dout
// one edge after it is written into an empty FIFO.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds overflow/underflow pulse outputs.
module sync_fwft_fifo_w144_d256
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] data_count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [WIDTH-1:0]  ram_q;
  logic              wr_acc;
  logic              rd_acc;
  logic              head_load;
  logic [CNT_W-1:0]  ram_avail;
  logic [CNT_W-1:0]  count_nxt;

  // Accept/pop decisions; ram_avail counts stored words not yet fetched to the head.
  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    ram_avail = data_count - CNT_W'(!empty);
    head_load = (ram_avail != '0) && (empty || rd_acc);
    count_nxt = data_count;
    if (wr_acc && !rd_acc) count_nxt = data_count + CNT_W'(1);
    if (!wr_acc && rd_acc) count_nxt = data_count - CNT_W'(1);
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      data_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      if (wr_acc)    wptr <= wptr + ADDR_W'(1);
      if (head_load) rptr <= rptr + ADDR_W'(1);
      data_count <= count_nxt;
      full       <= (count_nxt == CNT_W'(DEPTH));
      empty      <= !(head_load || (!empty && !rd_acc));
    end
  end

  fifo_sdp_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wptr),
    .wr_data (din),
    .rd_en   (head_load),
    .rd_addr (rptr),
    .rd_data (ram_q)
  );

  // Head word is forced to zero while nothing is presented (covers reset too).
  assign dout = empty ? '0 : ram_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // One-cycle pulses flagging a dropped write or an ignored read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fwft_fifo_w144_d256.sv
// Bench for the 144x256 FWFT FIFO: directed phases plus random traffic,
// checked against a queue model where each word carries the edge it was
// written on (a word is visible on dout only from the edge after its write).
module tb_sync_fwft_fifo_w144_d256;

  localparam int W = 144;
  localparam int D = 256;

  logic          clk;
  logic          rst;
  logic [W-1:0]  din;
  logic          wr_en;
  logic          rd_en;
  logic [W-1:0]  dout;
  logic          full;
  logic          empty;
  logic [8:0]    data_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  sync_fwft_fifo_w144_d256 dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .data_count (data_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int unsigned  e;
  } ent_t;

  ent_t        q[$];
  int unsigned edge_n = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic bit m_empty();
    if (q.size() == 0) return 1'b1;
    return (q[0].e == edge_n);
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check #1 later.
  task automatic step(input bit wr, input logic [W-1:0] d, input bit rd);
    bit was_full, was_empty, wacc, racc;
    ent_t en;
    was_full  = (q.size() == D);
    was_empty = m_empty();
    wacc = wr && !was_full;
    racc = rd && !was_empty;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    @(posedge clk);
    edge_n++;
    if (racc) void'(q.pop_front());
    if (wacc) begin
      en.d = d;
      en.e = edge_n;
      q.push_back(en);
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("count", 144'(data_count), 144'(q.size()));
    chk("full", 144'(full), 144'(q.size() == D));
    chk("empty", 144'(empty), 144'(m_empty()));
    if (!m_empty()) chk("dout", dout, q[0].d);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("overflow", 144'(overflow), 144'(wr && was_full));
    chk("underflow", 144'(underflow), 144'(rd && was_empty));
`endif
  endtask

  task automatic fill_to(input int n);
    int guard;
    guard = 0;
    while (q.size() < n && guard < 600) begin
      step(1'b1, rand_word(), 1'b0);
      guard++;
    end
    chk("fill_level", 144'(data_count), 144'(n));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 600) begin
      step(1'b0, '0, 1'b1);
      guard++;
    end
    chk("drain_empty", 144'(empty), 144'(1));
    chk("drain_count", 144'(data_count), 144'(0));
  endtask

  initial begin
    logic [W-1:0] prev;
    rst   = 1'b1;
    din   = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Reset state
    #3;
    chk("rst_empty", 144'(empty), 144'(1));
    chk("rst_full", 144'(full), 144'(0));
    chk("rst_count", 144'(data_count), 144'(0));
    chk("rst_dout", dout, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // First word latency
    step(1'b1, 144'h1, 1'b0);
    chk("fwft_cnt_n", 144'(data_count), 144'(1));
    chk("fwft_empty_n", 144'(empty), 144'(1));
    step(1'b0, '0, 1'b0);
    chk("fwft_empty_n1", 144'(empty), 144'(0));
    chk("fwft_dout_n1", dout, 144'h1);
    drain();

    // Fill to full with incrementing data, drop one extra write, read back in order
    for (int i = 0; i < D; i++) step(1'b1, 144'(i), 1'b0);
    chk("full_flag", 144'(full), 144'(1));
    chk("full_count", 144'(data_count), 144'(256));
    step(1'b1, 144'hDEAD, 1'b0);
    chk("drop_count", 144'(data_count), 144'(256));
    for (int i = 0; i < D; i++) begin
      chk("order", dout, 144'(i));
      step(1'b0, '0, 1'b1);
    end
    chk("after_read_empty", 144'(empty), 144'(1));
    chk("after_read_count", 144'(data_count), 144'(0));

    // Reads while empty are ignored
    prev = dout;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("udf_dout_hold", dout, prev);
    chk("udf_count", 144'(data_count), 144'(0));

    // Steady-state streaming across pointer wrap
    fill_to(241);
    for (int i = 0; i < 1000; i++) step(1'b1, rand_word(), 1'b1);
    chk("stream_count", 144'(data_count), 144'(241));
    drain();

    // Simultaneous read and write while full
    fill_to(256);
    step(1'b1, rand_word(), 1'b1);
    chk("full_rw_count", 144'(data_count), 144'(255));
    chk("full_rw_full", 144'(full), 144'(0));
    step(1'b0, '0, 1'b0);
    drain();

    // Simultaneous read and write while empty: write wins
    step(1'b1, 144'h77, 1'b1);
    chk("empty_rw_count", 144'(data_count), 144'(1));
    step(1'b0, '0, 1'b0);
    chk("empty_rw_dout", dout, 144'h77);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) < 55), rand_word(), ($urandom_range(0, 99) < 50));
    drain();

    // Asynchronous reset mid-stream
    fill_to(100);
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", 144'(empty), 144'(1));
    chk("mid_rst_count", 144'(data_count), 144'(0));
    chk("mid_rst_full", 144'(full), 144'(0));
    chk("mid_rst_dout", dout, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    step(1'b1, 144'hABC, 1'b0);
    chk("post_rst_empty_n", 144'(empty), 144'(1));
    chk("post_rst_cnt_n", 144'(data_count), 144'(1));
    step(1'b0, '0, 1'b0);
    chk("post_rst_dout", dout, 144'hABC);
    chk("post_rst_empty_n1", 144'(empty), 144'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
